// File: rtl/gate_deadtime.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// gate_deadtime : dead-time, shoot-through latch and enable for 4 bridge legs.
// Optional macro GATE_MINPULSE_EN adds a per-leg minimum on-time.  Rev 1.0
// ============================================================================
module gate_deadtime #(
  parameter int DT_CYCLES     = 20,
  parameter int CNT_W         = 8,
  parameter int MIN_ON_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fault_clr,
  input  logic [3:0] sp_cmd,
  input  logic [3:0] ss_cmd,
  output logic       Sp1,
  output logic       Sp2,
  output logic       Sp3,
  output logic       Sp4,
  output logic       Ss1,
  output logic       Ss2,
  output logic       Ss3,
  output logic       Ss4,
  output logic       fault,
  output logic [3:0] fault_leg
);

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_HI  = 2'd1,
    ST_LO  = 2'd2,
    ST_DT  = 2'd3
  } leg_state_t;

  localparam logic [CNT_W-1:0] c_dt_load = CNT_W'(DT_CYCLES - 1);

  if (DT_CYCLES < 1 || DT_CYCLES > 255 || MIN_ON_CYCLES < 1 || MIN_ON_CYCLES > 255 ||
      ((DT_CYCLES - 1) >> CNT_W) != 0 || ((MIN_ON_CYCLES - 1) >> CNT_W) != 0) begin : g_param_err
    $error("gate_deadtime: DT_CYCLES/MIN_ON_CYCLES out of range for CNT_W");
  end

  // Leg order matches fault_leg: {Ss3/4, Ss1/2, Sp3/4, Sp1/2}
  logic [3:0] w_h;
  logic [3:0] w_l;
  logic [3:0] w_st;
  logic       w_any_st;
  logic       w_hold;
  logic [3:0] w_up;
  logic [3:0] w_dn;
  logic       r_fault;
  logic [3:0] r_fault_leg;

  assign w_h      = {ss_cmd[2], ss_cmd[0], sp_cmd[2], sp_cmd[0]};
  assign w_l      = {ss_cmd[3], ss_cmd[1], sp_cmd[3], sp_cmd[1]};
  assign w_st     = en ? (w_h & w_l) : 4'b0000;
  assign w_any_st = |w_st;
  assign w_hold   = !en || w_any_st || r_fault;

  // A new overlap always beats a clear arriving on the same edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fault     <= 1'b0;
      r_fault_leg <= 4'b0000;
    end else if (w_any_st) begin
      r_fault     <= 1'b1;
      r_fault_leg <= r_fault_leg | w_st;
    end else if (fault_clr) begin
      r_fault     <= 1'b0;
      r_fault_leg <= 4'b0000;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_leg
    leg_state_t       r_state;
    leg_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_up;
    logic             r_dn;
    logic             w_on_ok;

`ifdef GATE_MINPULSE_EN
    localparam logic [CNT_W-1:0] c_min_load = CNT_W'(MIN_ON_CYCLES - 1);
    logic [CNT_W-1:0] r_mcnt;
    logic [CNT_W-1:0] w_mcnt_nxt;

    assign w_on_ok = (r_mcnt == '0);

    always_comb begin
      w_mcnt_nxt = r_mcnt;
      if ((w_state_nxt == ST_HI || w_state_nxt == ST_LO) && (w_state_nxt != r_state)) begin
        w_mcnt_nxt = c_min_load;
      end else if (r_mcnt != '0) begin
        w_mcnt_nxt = r_mcnt - CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_mcnt <= '0;
      end else begin
        r_mcnt <= w_mcnt_nxt;
      end
    end
`else
    assign w_on_ok = 1'b1;
`endif

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (w_hold) begin
        w_state_nxt = ST_DT;
        w_cnt_nxt   = c_dt_load;
      end else begin
        case (r_state)
          ST_OFF: begin
            if (w_h[i] && !w_l[i]) begin
              w_state_nxt = ST_HI;
            end else if (w_l[i] && !w_h[i]) begin
              w_state_nxt = ST_LO;
            end
          end
          ST_HI: begin
            if (!w_h[i] && w_on_ok) begin
              w_state_nxt = ST_DT;
              w_cnt_nxt   = c_dt_load;
            end
          end
          ST_LO: begin
            if (!w_l[i] && w_on_ok) begin
              w_state_nxt = ST_DT;
              w_cnt_nxt   = c_dt_load;
            end
          end
          default: begin
            // Commands are only looked at on the expiry cycle
            if (r_cnt == '0) begin
              if (w_h[i] && !w_l[i]) begin
                w_state_nxt = ST_HI;
              end else if (w_l[i] && !w_h[i]) begin
                w_state_nxt = ST_LO;
              end else begin
                w_state_nxt = ST_OFF;
              end
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_state <= ST_DT;
        r_cnt   <= c_dt_load;
        r_up    <= 1'b0;
        r_dn    <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_up    <= (w_state_nxt == ST_HI);
        r_dn    <= (w_state_nxt == ST_LO);
      end
    end

    assign w_up[i] = r_up;
    assign w_dn[i] = r_dn;
  end

  assign Sp1       = w_up[0];
  assign Sp2       = w_dn[0];
  assign Sp3       = w_up[1];
  assign Sp4       = w_dn[1];
  assign Ss1       = w_up[2];
  assign Ss2       = w_dn[2];
  assign Ss3       = w_up[3];
  assign Ss4       = w_dn[3];
  assign fault     = r_fault;
  assign fault_leg = r_fault_leg;

endmodule
`default_nettype wire

// File: tb/tb_gate_deadtime.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_gate_deadtime : scoreboard bench for gate_deadtime (DT_CYCLES=20).
// Honours GATE_MINPULSE_EN for the expected minimum on-time.  Rev 1.0
// ============================================================================
module tb_gate_deadtime;

  localparam int DT     = 20;
  localparam int MIN_ON = 10;
`ifdef GATE_MINPULSE_EN
  localparam int MIN_EFF   = MIN_ON;
  localparam int PULSE_EXP = MIN_ON;
`else
  localparam int MIN_EFF   = 1;
  localparam int PULSE_EXP = 3;
`endif
  localparam int M_OFF = 0;
  localparam int M_HI  = 1;
  localparam int M_LO  = 2;
  localparam int M_DT  = 3;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       en        = 1'b0;
  logic       fault_clr = 1'b0;
  logic [3:0] sp_cmd    = 4'b0000;
  logic [3:0] ss_cmd    = 4'b0000;
  logic       Sp1, Sp2, Sp3, Sp4, Ss1, Ss2, Ss3, Ss4;
  logic       fault;
  logic [3:0] fault_leg;
  wire logic [12:0] dut_vec = {fault_leg, fault, Ss4, Ss3, Ss2, Ss1, Sp4, Sp3, Sp2, Sp1};

  int          checks  = 0;
  int          errors  = 0;
  int          ncyc    = 0;
  logic        overlap = 1'b0;
  string       phase   = "init";
  logic [12:0] sb[$];

  int         m_mode[4];
  int         m_tmr[4];
  int         m_on[4];
  logic       m_fault = 1'b0;
  logic [3:0] m_fleg  = 4'b0000;

  gate_deadtime #(
    .DT_CYCLES    (DT),
    .CNT_W        (8),
    .MIN_ON_CYCLES(MIN_ON)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .fault_clr(fault_clr),
    .sp_cmd   (sp_cmd),
    .ss_cmd   (ss_cmd),
    .Sp1      (Sp1),
    .Sp2      (Sp2),
    .Sp3      (Sp3),
    .Sp4      (Sp4),
    .Ss1      (Ss1),
    .Ss2      (Ss2),
    .Ss3      (Ss3),
    .Ss4      (Ss4),
    .fault    (fault),
    .fault_leg(fault_leg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one clock edge, given the inputs currently applied
  task automatic model_edge();
    logic [3:0] h, l, st;
    logic       hold;
    h = {ss_cmd[2], ss_cmd[0], sp_cmd[2], sp_cmd[0]};
    l = {ss_cmd[3], ss_cmd[1], sp_cmd[3], sp_cmd[1]};
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        m_mode[i] = M_DT;
        m_tmr[i]  = DT - 1;
        m_on[i]   = 0;
      end
      m_fault = 1'b0;
      m_fleg  = 4'b0000;
      return;
    end
    st   = en ? (h & l) : 4'b0000;
    hold = !en || (st != 4'b0000) || m_fault;
    if (st != 4'b0000) begin
      m_fault = 1'b1;
      m_fleg  = m_fleg | st;
    end else if (fault_clr) begin
      m_fault = 1'b0;
      m_fleg  = 4'b0000;
    end
    for (int i = 0; i < 4; i++) begin
      if (hold) begin
        m_mode[i] = M_DT;
        m_tmr[i]  = DT - 1;
      end else if (m_mode[i] == M_OFF || (m_mode[i] == M_DT && m_tmr[i] == 0)) begin
        if (h[i] && !l[i]) begin
          m_mode[i] = M_HI;
          m_on[i]   = MIN_EFF - 1;
        end else if (l[i] && !h[i]) begin
          m_mode[i] = M_LO;
          m_on[i]   = MIN_EFF - 1;
        end else begin
          m_mode[i] = M_OFF;
        end
      end else if (m_mode[i] == M_DT) begin
        m_tmr[i] = m_tmr[i] - 1;
      end else if (m_on[i] > 0) begin
        m_on[i] = m_on[i] - 1;
      end else if ((m_mode[i] == M_HI && !h[i]) || (m_mode[i] == M_LO && !l[i])) begin
        m_mode[i] = M_DT;
        m_tmr[i]  = DT - 1;
      end
    end
  endtask

  function automatic logic [12:0] m_out();
    logic [3:0] sp, ss;
    for (int i = 0; i < 2; i++) begin
      sp[2*i]   = (m_mode[i] == M_HI);
      sp[2*i+1] = (m_mode[i] == M_LO);
      ss[2*i]   = (m_mode[i+2] == M_HI);
      ss[2*i+1] = (m_mode[i+2] == M_LO);
    end
    return {m_fleg, m_fault, ss, sp};
  endfunction

  // Inputs are applied 1 ns after a rising edge; outputs checked 1 ns after the next
  task automatic cyc();
    logic [12:0] exp;
    model_edge();
    sb.push_back(m_out());
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check($sformatf("%s_cyc%0d", phase, ncyc), 32'(dut_vec), 32'(exp));
    if ((Sp1 && Sp2) || (Sp3 && Sp4) || (Ss1 && Ss2) || (Ss3 && Ss4)) overlap = 1'b1;
    ncyc++;
  endtask

  initial begin
    int n;

    phase = "reset";
    repeat (3) cyc();
    check("reset_outputs", 32'(dut_vec), 32'd0);

    phase  = "first_on";
    rst    = 1'b1;
    en     = 1'b1;
    sp_cmd = 4'b0001;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!Sp1 && n < 40);
    check("sp1_first_on_delay", n, DT);
    repeat (3) cyc();

    phase  = "switchover";
    sp_cmd = 4'b0010;
    cyc();
    check("sp1_off_latency", Sp1, 1'b0);
    n = 0;
    while (!Sp2 && n < 40) begin
      cyc();
      n++;
    end
    check("sp2_on_after_dt", n, DT);

    phase  = "fault";
    sp_cmd = 4'b0000;
    ss_cmd = 4'b0001;
    repeat (25) cyc();
    check("ss1_on_before_fault", Ss1, 1'b1);
    sp_cmd = 4'b1100;
    cyc();
    check("fault_set", fault, 1'b1);
    check("fault_leg_sp34", fault_leg, 4'b0010);
    check("fault_gates_low", 32'(dut_vec[7:0]), 32'd0);
    fault_clr = 1'b1;
    ss_cmd    = 4'b0011;
    cyc();
    check("clr_ignored_in_overlap", fault, 1'b1);
    check("fault_leg_accumulate", fault_leg, 4'b0110);
    sp_cmd = 4'b0000;
    ss_cmd = 4'b0001;
    cyc();
    check("fault_cleared", fault, 1'b0);
    check("fault_leg_cleared", fault_leg, 4'b0000);
    fault_clr = 1'b0;
    n = 0;
    while (!Ss1 && n < 40) begin
      cyc();
      n++;
    end
    check("ss1_resume_after_clear", n, DT);
    repeat (3) cyc();

    phase = "enable";
    en    = 1'b0;
    cyc();
    check("ss1_off_on_disable", Ss1, 1'b0);
    sp_cmd = 4'b1100;
    repeat (3) cyc();
    check("no_fault_while_disabled", fault, 1'b0);
    sp_cmd = 4'b0000;
    en     = 1'b1;
    n = 0;
    while (!Ss1 && n < 40) begin
      cyc();
      n++;
    end
    check("ss1_on_after_enable", n, DT);

    phase  = "minpulse";
    ss_cmd = 4'b0000;
    repeat (25) cyc();
    ss_cmd = 4'b0010;
    n = 0;
    repeat (3) begin
      cyc();
      n += int'(Ss2);
    end
    ss_cmd = 4'b0000;
    repeat (30) begin
      cyc();
      n += int'(Ss2);
    end
    check("ss2_pulse_width", n, PULSE_EXP);

    phase  = "dt_toggle";
    sp_cmd = 4'b0001;
    cyc();
    check("sp1_on_from_off", Sp1, 1'b1);
    repeat (2) cyc();
    sp_cmd = 4'b0000;
    cyc();
    n = 0;
    for (int i = 0; i < 19; i++) begin
      sp_cmd = (i % 4 < 2) ? 4'b0001 : 4'b0000;
      cyc();
      n += int'(Sp1);
    end
    sp_cmd = 4'b0000;
    repeat (4) begin
      cyc();
      n += int'(Sp1);
    end
    check("dt_toggle_ends_off", n, 0);

    sp_cmd = 4'b0001;
    cyc();
    sp_cmd = 4'b0000;
    cyc();
    n = 0;
    for (int i = 0; i < 19; i++) begin
      sp_cmd = (i % 4 < 2) ? 4'b0000 : 4'b0001;
      cyc();
      n += int'(Sp1);
    end
    check("dt_toggle_quiet", n, 0);
    sp_cmd = 4'b0001;
    cyc();
    check("dt_expiry_follows_cmd", Sp1, 1'b1);
    repeat (3) cyc();

    check("no_complementary_overlap", overlap, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
